i2s_delay_sched: RTL
====================

# i2s_delay_sched

Frame sequencer and update arbiter for the bit-serial I2S delay lines. It tracks the `bclk`/`lrclk` pair in the system `clk` domain and locks to the I2S frame, which has a one-bit offset. It arbitrates delay-change requests from several masters round-robin and holds them per channel. Each delay value is applied only at the start of its channel's slot, so a delay line never switches mid-word. The block sits between the control masters and the per-channel delay lines, which consume `delay_l` / `delay_r`.

## Interface
- `w_delay`, 32, bits per channel slot
- `max_delay`, 1, largest legal delay; delay width DW = $clog2(max_delay + 1)
- `n_req`, 2, number of requesters (at least 1)

- `clk` in 1: system clock, oversamples `bclk`
- `rst` in 1: reset, synchronous, active-high
- `bclk` in 1: I2S bit clock, sampled by `clk`
- `lrclk` in 1: I2S word select; 0 = left, 1 = right
- `req_valid` in n_req: update request, one bit per requester
- `req_chan` in n_req: target channel per requester; 0 = left, 1 = right
- `req_delay` in n_req*DW: requested delay; requester i uses bits [i*DW +: DW]
- `req_ready` out n_req: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`
- `delay_l`, `delay_r` out DW: applied delay per channel
- `lock` out 1: frame tracking is locked
- `slot_start` out 1: one-`clk` pulse when a slot's first data bit is recorded
- `chan` out 1: channel of the current slot
- `bit_cnt` out $clog2(w_delay+1): data bits recorded in the current slot; saturates at `w_delay`
- `range_err` out 1: one-`clk` pulse when an accepted delay exceeds `max_delay`

## Operation
- Edge detect: register `bclk` to `bclk_prev`.
  - Falling edge (fall) = `bclk_prev & !bclk`, the play edge.
  - Rising edge (rise) = `!bclk_prev & bclk`, the record edge.
- `lrclk` is sampled on fall only. An lrclk change is detected by comparing the sample with the previous sample.
- FSM states, advanced on fall:
  - UNLOCKED → OFFSET on an lrclk change.
  - OFFSET → SLOT on the next fall. This is the I2S one-bit offset.
  - SLOT → OFFSET on an lrclk change.
  - SLOT → UNLOCKED on timeout (only when `I2S_DELAY_SCHED_TIMEOUT_EN` is defined).
- Outputs driven by FSM state:
  - `lock` = 1 in OFFSET and in SLOT.
  - `chan` is latched from the sampled `lrclk` on entry to OFFSET.
- Slot start and bit count:
  - The first rise in SLOT is the slot start. `slot_start` = 1 on that rise cycle.
  - `bit_cnt` loads 1 on the slot start rise, then increments on each later rise, saturating at `w_delay`.
  - `bit_cnt` is cleared when OFFSET is entered.
- Arbitration:
  - Round-robin pointer `rr`. Grant the first asserted `req_valid` at or after `rr`, scanning upward and wrapping.
  - `req_ready` is combinational from `req_valid` and `rr`. At most one bit of `req_ready` is set, and it is set only where the matching `req_valid` bit is set.
  - After a transfer by requester g, `rr` = (g + 1) mod n_req. With no transfer, `rr` holds.
- Pending registers: `pend_l`/`pend_r` with valid flags `pv_l`/`pv_r`.
  - A transfer writes the requested value into the pending register of `req_chan` and sets its valid flag. A newer transfer overwrites an unapplied pending value.
  - `range_err` pulses when the transferred value is greater than `max_delay`. The value is stored unmodified; the delay line mutes for out-of-range values.
- Apply:
  - On slot start for channel c, if `pv_c` is set, copy `pend_c` into `delay_c` and clear `pv_c`.
  - If a transfer to channel c and the apply for c occur in the same cycle, apply the old pending value. The new value stays pending, with `pv_c` = 1, until the next slot of c.
- While UNLOCKED, no apply happens. Requests are still accepted and held.

## Timing
- `req_ready` is combinational, with 0-cycle latency from `req_valid`. At most one grant per `clk`.
- Pending is updated on the `clk` edge after a transfer. `range_err` asserts in that same cycle.
- Apply latency: `delay_c` updates on the `clk` edge of the slot-start rise. It is visible one `clk` after `slot_start`.
- `rst` has priority over all events. On reset:
  - FSM = UNLOCKED; `lock`, `slot_start`, `range_err` = 0.
  - `delay_l`, `delay_r`, `bit_cnt`, `chan`, `rr` = 0; both pending flags cleared.
  - `req_ready` = 0 for the cycle in which `rst` is high.
  - `bclk_prev` and the `lrclk` sample are loaded from the inputs during reset, so no edge is reported on the first cycle after reset.
- A reset in mid-slot drops all pending requests and relocks on the next lrclk change.

## Configuration
- `I2S_DELAY_SCHED_TIMEOUT_EN` defined:
  - A counter counts falls in SLOT and clears on each lrclk change.
  - At 2*`w_delay` falls without an lrclk change, the FSM enters UNLOCKED and `lock` drops. `delay_l` and `delay_r` hold their values.
- Not defined: there is no counter, and the FSM leaves lock only through `rst`.

## Test plan
- Reset, then lrclk toggles 0→1, w_delay=32, bclk = clk/8:
  - `lock` rises on the fall where the change is detected.
  - `slot_start` pulses at the second rise after the change, with `chan`=1.
  - `bit_cnt` reaches 32 and holds.
- Requester 0 writes left=1 while locked in the right slot → `delay_l` stays 0 until the next left slot start, then becomes 1. `delay_r` remains 0.
- n_req=2, both valid continuously, rr=0 → grants alternate 0,1,0,1 on successive clk cycles. Never two grants in one cycle.
- Transfer to left lands in the same cycle as the left slot-start apply → the old pending value is applied. The new value is applied one frame later.
- max_delay=1, request delay=1 in DW=1 passes with no error. With max_delay=2, DW=2, request 3 → `range_err` pulses once, and `delay_*` becomes 3 at the next slot.
- With the macro defined, stop `lrclk` for 64 falls → `lock` drops and delays hold. Without the macro, `lock` stays 1. In both builds, `rst` mid-slot clears `delay_l`/`delay_r` to 0.

Source files
------------

// File: rtl/i2s_delay_sched_if.sv
// rtl/i2s_delay_sched_if.sv - delay-change request bus between control masters and i2s_delay_sched
interface i2s_delay_sched_if #(
  parameter int n_req = 2,
  parameter int dw    = 1
);
  logic [n_req-1:0]    req_valid;
  logic [n_req-1:0]    req_chan;
  logic [n_req*dw-1:0] req_delay;
  logic [n_req-1:0]    req_ready;

  modport master (output req_valid, req_chan, req_delay, input req_ready);
  modport slave  (input req_valid, req_chan, req_delay, output req_ready);
endinterface

// File: rtl/i2s_delay_sched.sv
// rtl/i2s_delay_sched.sv - I2S frame lock, round-robin delay update arbiter, slot-aligned apply
// Optional lock timeout: define I2S_DELAY_SCHED_TIMEOUT_EN.
module i2s_delay_sched #(
  parameter int w_delay   = 32,
  parameter int max_delay = 1,
  parameter int n_req     = 2,
  localparam int DW = $clog2(max_delay + 1),
  localparam int BW = $clog2(w_delay + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bclk,
  input  logic             lrclk,
  i2s_delay_sched_if.slave req,
  output logic [DW-1:0]    delay_l,
  output logic [DW-1:0]    delay_r,
  output logic             lock,
  output logic             slot_start,
  output logic             chan,
  output logic [BW-1:0]    bit_cnt,
  output logic             range_err
);
  localparam int RW = (n_req > 1) ? $clog2(n_req) : 1;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_OFFSET, ST_SLOT} state_t;

  state_t        state_q, state_d;
  logic          bclk_prev;
  logic          lr_s;
  logic          fall, rise, lr_chg, timeout;
  logic          started;
  logic [RW-1:0] rr;
  logic          xfer;
  logic [RW-1:0] gnt_idx;
  logic          xfer_chan;
  logic [DW-1:0] xfer_val;
  logic [DW-1:0] pend_l, pend_r;
  logic          pv_l, pv_r;
  int            scan_idx;
  logic [DW-1:0] req_val [n_req];

  assign fall   = bclk_prev & ~bclk;
  assign rise   = ~bclk_prev & bclk;
  assign lr_chg = fall & (lrclk ^ lr_s);

`ifdef I2S_DELAY_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(2 * w_delay + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_SLOT || lr_chg) begin
      tmo_cnt <= '0;
    end else if (fall) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires on the 2*w_delay-th fall spent in SLOT without an lrclk change.
  assign timeout = (state_q == ST_SLOT) && fall && !lr_chg && (tmo_cnt == TW'(2 * w_delay - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNLOCKED: if (lr_chg) state_d = ST_OFFSET;
      ST_OFFSET:   if (fall) state_d = ST_SLOT;
      ST_SLOT: begin
        if (lr_chg) begin
          state_d = ST_OFFSET;
        end else if (timeout) begin
          state_d = ST_UNLOCKED;
        end
      end
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  assign lock       = (state_q != ST_UNLOCKED);
  assign slot_start = ~rst & (state_q == ST_SLOT) & rise & ~started;

  always_ff @(posedge clk) begin
    bclk_prev <= bclk;
    if (rst) begin
      state_q <= ST_UNLOCKED;
      lr_s    <= lrclk;
      chan    <= 1'b0;
      bit_cnt <= '0;
      started <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fall) lr_s <= lrclk;
      if (state_q != ST_OFFSET && state_d == ST_OFFSET) begin
        chan    <= lrclk;
        bit_cnt <= '0;
        started <= 1'b0;
      end else if (state_q == ST_SLOT && rise) begin
        started <= 1'b1;
        if (!started) begin
          bit_cnt <= BW'(1);
        end else if (bit_cnt != BW'(w_delay)) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < n_req; g++) begin : g_req_val
    assign req_val[g] = req.req_delay[g*DW +: DW];
  end

  // First valid requester at or after rr, wrapping.
  always_comb begin
    req.req_ready = '0;
    xfer          = 1'b0;
    gnt_idx       = '0;
    scan_idx      = 0;
    if (!rst) begin
      for (int k = 0; k < n_req; k++) begin
        scan_idx = (int'(rr) + k) % n_req;
        if (!xfer && req.req_valid[RW'(scan_idx)]) begin
          xfer    = 1'b1;
          gnt_idx = RW'(scan_idx);
        end
      end
      req.req_ready[gnt_idx] = xfer;
    end
  end

  assign xfer_chan = req.req_chan[gnt_idx];
  assign xfer_val  = req_val[gnt_idx];

  // Apply is ordered before the transfer write so a same-cycle transfer stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= '0;
      pend_l    <= '0;
      pend_r    <= '0;
      pv_l      <= 1'b0;
      pv_r      <= 1'b0;
      delay_l   <= '0;
      delay_r   <= '0;
      range_err <= 1'b0;
    end else begin
      range_err <= xfer && (32'(xfer_val) > 32'(max_delay));
      if (xfer) rr <= (gnt_idx == RW'(n_req - 1)) ? '0 : gnt_idx + 1'b1;
      if (slot_start && !chan && pv_l) begin
        delay_l <= pend_l;
        pv_l    <= 1'b0;
      end
      if (slot_start && chan && pv_r) begin
        delay_r <= pend_r;
        pv_r    <= 1'b0;
      end
      if (xfer && !xfer_chan) begin
        pend_l <= xfer_val;
        pv_l   <= 1'b1;
      end
      if (xfer && xfer_chan) begin
        pend_r <= xfer_val;
        pv_r   <= 1'b1;
      end
    end
  end

endmodule
